// File: rtl/enc_par_serializer.sv
// Serializes one codeword's parity symbols into ENC_SYM-lane beats, highest-degree first.
// Valid/ready on both sides; sticky ovf_err flags parity offered while busy.
module enc_par_serializer #(
  parameter int unsigned EGF_DIM     = 8,
  parameter int unsigned ENC_SYM     = 6,
  parameter int unsigned RSC_PAR_LEN = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  par_valid,
  input  logic [RSC_PAR_LEN-1:0][EGF_DIM-1:0]   par_data,
  output logic                                  par_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ENC_SYM-1:0][EGF_DIM-1:0]       out_data,
  output logic [$clog2(ENC_SYM+1)-1:0]          out_cnt,
  output logic                                  out_last,
  output logic                                  ovf_err
);

  localparam int unsigned BEATS    = (RSC_PAR_LEN + ENC_SYM - 1) / ENC_SYM;
  localparam int unsigned LAST_CNT = RSC_PAR_LEN - (BEATS - 1) * ENC_SYM;
  localparam int unsigned CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OUT_CW   = $clog2(ENC_SYM + 1);
  localparam int unsigned PAD      = BEATS * ENC_SYM;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                              state;
  logic [CNT_W-1:0]                    beat_cnt;
  logic [RSC_PAR_LEN-1:0][EGF_DIM-1:0] par_q;
  logic [PAD-1:0][EGF_DIM-1:0]         padded;
  logic                                load;
  logic                                fire;

  assign out_valid = (state == SEND);
  assign out_last  = (state == SEND) && (beat_cnt == CNT_W'(BEATS - 1));
  assign fire      = out_valid & out_ready;
  assign par_ready = !rst && ((state == IDLE) || (out_last && out_ready));
  assign load      = par_valid & par_ready;

  // Zero-extend below the last parity symbol so every beat slice is in range.
  always_comb begin
    padded = '0;
    padded[PAD-1 -: RSC_PAR_LEN] = par_q;
  end

  always_comb begin
    out_data = '0;
    out_cnt  = '0;
    if (state == SEND) begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (beat_cnt == CNT_W'(k)) begin
          for (int unsigned s = 0; s < ENC_SYM; s++) begin
            out_data[ENC_SYM-1-s] = padded[PAD-1-(k*ENC_SYM+s)];
          end
        end
      end
      out_cnt = out_last ? OUT_CW'(LAST_CNT) : OUT_CW'(ENC_SYM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      par_q    <= '0;
      ovf_err  <= 1'b0;
    end else begin
      if (par_valid && !par_ready) ovf_err <= 1'b1;
      if (load) begin
        par_q    <= par_data;
        beat_cnt <= '0;
        state    <= SEND;
      end else if (fire) begin
        if (out_last) begin
          state    <= IDLE;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_enc_par_serializer.sv
// Directed per-cycle vector table for the default configuration, plus a short
// sequence exercising the single-beat and evenly-divided configurations.
module tb_enc_par_serializer;

  logic clk = 1'b0;
  logic rst;
  logic par_valid;
  logic out_ready;
  logic [15:0][7:0] par_data;

  logic             par_ready, out_valid, out_last, ovf_err;
  logic [5:0][7:0]  out_data;
  logic [2:0]       out_cnt;

  logic             pr16, ov16, last16, ovf16;
  logic [15:0][7:0] data16;
  logic [4:0]       cnt16;

  logic             pr4, ov4, last4, ovf4;
  logic [3:0][7:0]  data4;
  logic [2:0]       cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  enc_par_serializer #(.EGF_DIM(8), .ENC_SYM(6), .RSC_PAR_LEN(16)) dut (
    .clk(clk), .rst(rst), .par_valid(par_valid), .par_data(par_data),
    .par_ready(par_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cnt(out_cnt), .out_last(out_last), .ovf_err(ovf_err));

  enc_par_serializer #(.EGF_DIM(8), .ENC_SYM(16), .RSC_PAR_LEN(16)) dut16 (
    .clk(clk), .rst(rst), .par_valid(par_valid), .par_data(par_data),
    .par_ready(pr16), .out_valid(ov16), .out_ready(out_ready),
    .out_data(data16), .out_cnt(cnt16), .out_last(last16), .ovf_err(ovf16));

  enc_par_serializer #(.EGF_DIM(8), .ENC_SYM(4), .RSC_PAR_LEN(16)) dut4 (
    .clk(clk), .rst(rst), .par_valid(par_valid), .par_data(par_data),
    .par_ready(pr4), .out_valid(ov4), .out_ready(out_ready),
    .out_data(data4), .out_cnt(cnt4), .out_last(last4), .ovf_err(ovf4));

  typedef struct {
    logic        rst;
    logic        pv;
    logic        dsel;
    logic        ordy;
    logic        pr;
    logic        ov;
    logic [2:0]  cnt;
    logic        last;
    logic [47:0] d;
    logic        ovf;
  } vec_t;

  localparam logic [47:0] A0 = 48'h100F0E0D0C0B;
  localparam logic [47:0] A1 = 48'h0A0908070605;
  localparam logic [47:0] A2 = 48'h040302010000;
  localparam logic [47:0] B0 = 48'h302F2E2D2C2B;
  localparam logic [47:0] B1 = 48'h2A2928272625;
  localparam logic [47:0] B2 = 48'h242322210000;

  logic [15:0][7:0] pat_a, pat_b;
  vec_t vecs [25];

  function automatic vec_t mk(logic r, logic pv, logic ds, logic o, logic pr, logic ov,
                              logic [2:0] c, logic l, logic [47:0] d, logic f);
    vec_t t;
    t.rst = r; t.pv = pv; t.dsel = ds; t.ordy = o;
    t.pr = pr; t.ov = ov; t.cnt = c; t.last = l; t.d = d; t.ovf = f;
    return t;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      pat_a[i] = 8'(i + 1);
      pat_b[i] = 8'(i + 'h21);
    end

    //            rst pv ds o   pr ov cnt last data ovf
    vecs[0]  = mk(1, 0, 0, 0,  0, 0, 0, 0, '0, 0);
    vecs[1]  = mk(0, 1, 0, 1,  1, 0, 0, 0, '0, 0);
    vecs[2]  = mk(0, 0, 0, 1,  0, 1, 6, 0, A0, 0);
    vecs[3]  = mk(0, 0, 0, 1,  0, 1, 6, 0, A1, 0);
    vecs[4]  = mk(0, 0, 0, 1,  1, 1, 4, 1, A2, 0);
    vecs[5]  = mk(0, 0, 0, 1,  1, 0, 0, 0, '0, 0);
    vecs[6]  = mk(0, 0, 0, 0,  1, 0, 0, 0, '0, 0);
    vecs[7]  = mk(0, 1, 0, 0,  1, 0, 0, 0, '0, 0);
    vecs[8]  = mk(0, 0, 0, 1,  0, 1, 6, 0, A0, 0);
    vecs[9]  = mk(0, 0, 0, 0,  0, 1, 6, 0, A1, 0);
    vecs[10] = mk(0, 0, 0, 0,  0, 1, 6, 0, A1, 0);
    vecs[11] = mk(0, 0, 0, 0,  0, 1, 6, 0, A1, 0);
    vecs[12] = mk(0, 0, 0, 0,  0, 1, 6, 0, A1, 0);
    vecs[13] = mk(0, 0, 0, 0,  0, 1, 6, 0, A1, 0);
    vecs[14] = mk(0, 0, 0, 1,  0, 1, 6, 0, A1, 0);
    vecs[15] = mk(0, 1, 1, 1,  1, 1, 4, 1, A2, 0);
    vecs[16] = mk(0, 0, 0, 1,  0, 1, 6, 0, B0, 0);
    vecs[17] = mk(0, 0, 0, 1,  0, 1, 6, 0, B1, 0);
    vecs[18] = mk(0, 0, 0, 1,  1, 1, 4, 1, B2, 0);
    vecs[19] = mk(0, 1, 0, 0,  1, 0, 0, 0, '0, 0);
    vecs[20] = mk(0, 1, 1, 0,  0, 1, 6, 0, A0, 0);
    vecs[21] = mk(0, 0, 0, 1,  0, 1, 6, 0, A0, 1);
    vecs[22] = mk(1, 1, 1, 1,  0, 1, 6, 0, A1, 1);
    vecs[23] = mk(0, 0, 0, 1,  1, 0, 0, 0, '0, 0);
    vecs[24] = mk(0, 0, 0, 0,  1, 0, 0, 0, '0, 0);

    rst = 1'b1; par_valid = 1'b0; out_ready = 1'b0; par_data = pat_a;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      par_valid = vecs[i].pv;
      out_ready = vecs[i].ordy;
      par_data  = vecs[i].dsel ? pat_b : pat_a;
      #2;
      check($sformatf("r%0d.par_ready", i), 128'(par_ready), 128'(vecs[i].pr));
      check($sformatf("r%0d.out_valid", i), 128'(out_valid), 128'(vecs[i].ov));
      check($sformatf("r%0d.out_cnt", i),   128'(out_cnt),   128'(vecs[i].cnt));
      check($sformatf("r%0d.out_last", i),  128'(out_last),  128'(vecs[i].last));
      check($sformatf("r%0d.out_data", i),  128'(out_data),  128'(vecs[i].d));
      check($sformatf("r%0d.ovf_err", i),   128'(ovf_err),   128'(vecs[i].ovf));
    end

    // Configuration sweep: all instances reset together, then load pattern A.
    @(negedge clk);
    rst = 1'b1; par_valid = 1'b0; out_ready = 1'b1; par_data = pat_a;
    @(negedge clk);
    rst = 1'b0; par_valid = 1'b1;
    #2;
    check("sw.pr16_idle", 128'(pr16), 128'(1));
    check("sw.pr4_idle",  128'(pr4),  128'(1));
    @(negedge clk);
    par_valid = 1'b0;
    #2;
    check("sw16.valid", 128'(ov16),   128'(1));
    check("sw16.cnt",   128'(cnt16),  128'(16));
    check("sw16.last",  128'(last16), 128'(1));
    check("sw16.data",  128'(data16), 128'h100F0E0D0C0B0A090807060504030201);
    check("sw16.ready", 128'(pr16),   128'(1));
    check("sw4.b0.data", 128'(data4), 128'h100F0E0D);
    check("sw4.b0.cnt",  128'(cnt4),  128'(4));
    check("sw4.b0.last", 128'(last4), 128'(0));
    @(negedge clk);
    #2;
    check("sw16.idle",   128'(ov16),  128'(0));
    check("sw16.cnt0",   128'(cnt16), 128'(0));
    check("sw4.b1.data", 128'(data4), 128'h0C0B0A09);
    check("sw4.b1.last", 128'(last4), 128'(0));
    @(negedge clk);
    #2;
    check("sw4.b2.data", 128'(data4), 128'h08070605);
    check("sw4.b2.cnt",  128'(cnt4),  128'(4));
    @(negedge clk);
    #2;
    check("sw4.b3.data", 128'(data4), 128'h04030201);
    check("sw4.b3.cnt",  128'(cnt4),  128'(4));
    check("sw4.b3.last", 128'(last4), 128'(1));
    check("sw4.b3.ready", 128'(pr4),  128'(1));
    @(negedge clk);
    #2;
    check("sw4.idle",    128'(ov4),   128'(0));
    check("sw4.ovf",     128'(ovf4),  128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/enc_par_serializer.md
ENC_PAR_SERIALIZER -- requirements
Module: enc_par_serializer

Interface
REQ-001 SHALL have parameter EGF_DIM, default 8, meaning bits per Galois-field symbol.
REQ-002 SHALL have parameter ENC_SYM, default 6, meaning symbols per output beat.
REQ-003 SHALL have parameter RSC_PAR_LEN, default 16, meaning parity symbols per codeword.
REQ-004 SHALL derive local constant BEATS = ceil(RSC_PAR_LEN / ENC_SYM), which is 3 at defaults.
REQ-005 SHALL derive local constant LAST_CNT = RSC_PAR_LEN - (BEATS-1)*ENC_SYM, which is 4 at defaults.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port par_valid, input, 1 bit: final parity of the processor stage is present on par_data.
REQ-009 SHALL have port par_data, input, [RSC_PAR_LEN-1:0][EGF_DIM-1:0]: parity symbols; index RSC_PAR_LEN-1 is the highest-degree coefficient.
REQ-010 SHALL have port par_ready, output, 1 bit: the block accepts par_data this cycle.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data beat is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream sink accepts the beat.
REQ-013 SHALL have port out_data, output, [ENC_SYM-1:0][EGF_DIM-1:0]: parity beat; lane ENC_SYM-1 is first in time.
REQ-014 SHALL have port out_cnt, output, $clog2(ENC_SYM+1) bits: number of valid lanes in the beat, counted from lane ENC_SYM-1 downward.
REQ-015 SHALL have port out_last, output, 1 bit: marks the final parity beat of the codeword.
REQ-016 SHALL have port ovf_err, output, 1 bit: sticky flag for a parity load that was dropped.

Function
REQ-017 SHALL implement a two-state FSM with states IDLE and SEND.
REQ-018 SHALL define load = par_valid & par_ready.
REQ-019 SHALL define fire = out_valid & out_ready.
REQ-020 SHALL drive par_ready = (state==IDLE) | (state==SEND & out_last & out_ready); this is combinational and supports back-to-back codewords.
REQ-021 SHALL, on load, capture par_data into an internal register par_q, set beat_cnt=0 and enter or stay in SEND, in the same cycle.
REQ-022 SHALL assert out_valid exactly when state==SEND, i.e. one cycle after load, so load-to-first-beat latency is 1 cycle.
REQ-023 SHALL drive out_data in beat k as out_data[ENC_SYM-1-s] = par_q[RSC_PAR_LEN-1-(k*ENC_SYM+s)] for every valid s.
REQ-024 SHALL drive the unused lanes of the last beat to 0.
REQ-025 SHALL drive out_cnt = ENC_SYM for beats 0..BEATS-2 and out_cnt = LAST_CNT for beat BEATS-1.
REQ-026 SHALL drive out_last = (state==SEND) & (beat_cnt==BEATS-1).
REQ-027 SHALL increment beat_cnt on fire when out_last=0.
REQ-028 SHALL, on fire with out_last=1, go to IDLE, unless a load occurs in the same cycle, in which case it stays in SEND with beat_cnt=0.
REQ-029 SHALL hold out_data, out_cnt, out_last and out_valid stable while out_valid=1 and out_ready=0; there SHALL be no beat skipping.
REQ-030 SHALL, when par_valid=1 and par_ready=0, ignore par_data, leave par_q unchanged and set ovf_err to 1.
REQ-031 SHALL keep ovf_err at 1 until rst.
REQ-032 SHALL force out_data, out_cnt and out_last to 0 in IDLE.
REQ-033 SHALL treat out_ready as don't-care in IDLE.
REQ-034 SHALL, when BEATS==1, assert out_last on the only beat and set out_cnt=RSC_PAR_LEN.
REQ-035 SHALL size beat_cnt to $clog2(BEATS) bits, minimum 1, with no wrap beyond BEATS-1.

Reset
REQ-036 SHALL, while rst=1 at a clk edge, set state=IDLE, beat_cnt=0, par_q=0 and ovf_err=0.
REQ-037 SHALL, during and after reset, present out_valid=0, out_data=0, out_cnt=0 and out_last=0.
REQ-038 SHALL keep par_ready=0 while rst=1.
REQ-039 SHALL, on rst asserted mid-SEND, abort the codeword; the next codeword requires a new load after rst deasserts.
REQ-040 SHALL give rst priority over load and fire in the same cycle.

Verification
REQ-041 SHALL cover a basic codeword: par_data[i]=i+1, out_ready=1 -> beat0 lanes5..0=10,0F,0E,0D,0C,0B (hex), cnt=6; beat1=0A..05, cnt=6; beat2 lanes5..2=04,03,02,01, lanes1..0=00, cnt=4, last=1; then IDLE.
REQ-042 SHALL cover backpressure: out_ready=0 for 5 cycles on beat1 -> beat1 held unchanged, then beat2 follows on the cycle after out_ready rises.
REQ-043 SHALL cover back-to-back codewords: the second par_valid is asserted in the same cycle as the last-beat fire -> par_ready=1, next cycle beat0 of the new codeword with no bubble.
REQ-044 SHALL cover overflow: par_valid=1 during beat0 with out_ready=0 -> ovf_err=1, first codeword output unchanged, ovf_err stays 1 until rst.
REQ-045 SHALL cover reset mid-operation: rst=1 for 1 cycle during beat1 -> out_valid=0, ovf_err=0 next cycle, par_ready=1 after rst drops.
REQ-046 SHALL cover a parameter sweep: ENC_SYM=16 (BEATS=1) and ENC_SYM=4 (LAST_CNT=4, no padding) -> out_cnt/out_last per REQ-025/026/034.
